fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC generator, registered IMEM
// request port and DEPTH-entry prefetch queue with redirect flush and halt stop.
module fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                DEPTH      = 4,
  parameter int                PC_STEP    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INSTR_W-1:0]           inst,
  output logic [ADDR_W-1:0]            inst_pc,
  output logic [ADDR_W-1:0]            inst_pc_next,
  output logic [ADDR_W-1:0]            pc,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    L_DEPTH = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_STEP  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_kill;
  logic               r_halt_seen;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [INSTR_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];

  logic               w_resp_valid;
  logic               w_is_hlt;
  logic               w_deq;
  logic [CNT_W:0]     w_credit;

  assign w_resp_valid = r_inflight & ~r_kill;
  assign w_is_hlt     = w_resp_valid & (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);
  assign w_deq        = inst_valid & inst_ready;
  // Credit counts the in-flight slot and ignores a same-cycle dequeue, so the queue cannot overflow.
  assign w_credit     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};

  assign imem_req     = rst_n & ~redirect & ~r_halt_seen & ~w_is_hlt & (w_credit < L_DEPTH);
  assign imem_addr    = r_fetch_pc;
  assign pc           = r_fetch_pc;

  assign inst_valid   = (r_count != '0);
  assign inst         = inst_valid ? r_q_instr[r_rd_ptr] : '0;
  assign inst_pc      = inst_valid ? r_q_pc[r_rd_ptr] : '0;
  assign inst_pc_next = inst_pc + L_STEP;
  assign halted       = r_halt_seen & (r_count == '0) & ~r_inflight;
  assign occupancy    = r_count;

  always_ff @(posedge clk) begin
    if (w_resp_valid) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
      r_halt_seen   <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect) begin
      // The queue is flushed; anything still in flight is killed on arrival.
      r_fetch_pc  <= redirect_pc;
      r_inflight  <= 1'b0;
      r_kill      <= r_inflight;
      r_halt_seen <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_kill      <= 1'b0;
      r_inflight  <= imem_req;
      r_halt_seen <= r_halt_seen | w_is_hlt;
      if (imem_req) begin
        r_fetch_pc    <= r_fetch_pc + L_STEP;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_resp_valid) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq)        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_resp_valid, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: queue-based reference model
// compared every cycle, plus directed literal checks on a default and a wrapping instance.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_ready;
  logic        hlt_en;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_next;
  logic [15:0] pc;
  logic        halted;
  logic [2:0]  occupancy;

  logic        wp_imem_req;
  logic [15:0] wp_imem_addr;
  logic [15:0] wp_imem_rdata;
  logic        wp_inst_valid;
  logic [15:0] wp_inst;
  logic [15:0] wp_inst_pc;
  logic [15:0] wp_inst_pc_next;
  logic [15:0] wp_pc;
  logic        wp_halted;
  logic [2:0]  wp_occupancy;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_next(inst_pc_next), .pc(pc), .halted(halted), .occupancy(occupancy)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(wp_imem_req), .imem_addr(wp_imem_addr),
    .imem_rdata(wp_imem_rdata), .redirect(1'b0), .redirect_pc(16'h0000),
    .inst_valid(wp_inst_valid), .inst_ready(1'b1), .inst(wp_inst), .inst_pc(wp_inst_pc),
    .inst_pc_next(wp_inst_pc_next), .pc(wp_pc), .halted(wp_halted), .occupancy(wp_occupancy)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'h0006) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  always @(posedge clk) if (imem_req)    imem_rdata    <= mem_word(imem_addr);
  always @(posedge clk) if (wp_imem_req) wp_imem_rdata <= {4'h2, wp_imem_addr[11:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference model: fetch address, one pending request, halt flag, queue of fetched PCs.
  logic [15:0] m_q[$];
  logic [15:0] m_fetch   = 16'h0000;
  logic [15:0] m_pend_pc = 16'h0000;
  bit          m_pend    = 1'b0;
  bit          m_kill    = 1'b0;
  bit          m_halt    = 1'b0;
  bit          m_resp, m_hlt, m_req;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", imem_req, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_halted", halted, 0);
      check("rst_occ", occupancy, 0);
      check("rst_pc", pc, 16'h0000);
      m_q.delete();
      m_fetch = 16'h0000;
      m_pend  = 1'b0;
      m_kill  = 1'b0;
      m_halt  = 1'b0;
    end else begin
      m_resp = m_pend && !m_kill;
      m_hlt  = m_resp && (mem_word(m_pend_pc) >> 12) == 16'hF;
      m_req  = !redirect && !m_halt && !m_hlt && (m_q.size() + int'(m_pend) < 4);
      check("m_req", imem_req, m_req);
      check("m_addr", imem_addr, m_fetch);
      check("m_pc", pc, m_fetch);
      check("m_valid", inst_valid, m_q.size() != 0);
      check("m_occ", occupancy, m_q.size());
      check("m_halted", halted, m_halt && m_q.size() == 0 && !m_pend);
      if (m_q.size() != 0) begin
        check("m_inst", inst, mem_word(m_q[0]));
        check("m_inst_pc", inst_pc, m_q[0]);
        check("m_inst_pc_next", inst_pc_next, 16'(m_q[0] + 16'd2));
      end
      if (redirect) begin
        m_q.delete();
        m_kill  = m_pend;
        m_pend  = 1'b0;
        m_fetch = redirect_pc;
        m_halt  = 1'b0;
      end else begin
        if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
        if (m_resp) m_q.push_back(m_pend_pc);
        m_halt = m_halt || m_hlt;
        m_kill = 1'b0;
        if (m_req) begin
          m_pend    = 1'b1;
          m_pend_pc = m_fetch;
          m_fetch   = m_fetch + 16'd2;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b1; hlt_en = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("r_req", imem_req, 0);
    check("r_valid", inst_valid, 0);
    check("r_wrap_pc", wp_pc, 16'hFFFC);
    check("r_wrap_halted", wp_halted, 0);

    // Sequential fetch from reset, ending at the HLT at 0x0006.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("c0_req", imem_req, 1);
    check("c0_addr", imem_addr, 16'h0000);
    check("c0_valid", inst_valid, 0);
    check("c0_wrap_addr", wp_imem_addr, 16'hFFFC);
    cyc(); #1;
    check("c1_addr", imem_addr, 16'h0002);
    check("c1_valid", inst_valid, 0);
    check("c1_wrap_addr", wp_imem_addr, 16'hFFFE);
    cyc(); #1;
    check("c2_valid", inst_valid, 1);
    check("c2_inst_pc", inst_pc, 16'h0000);
    check("c2_inst", inst, 16'h1000);
    check("c2_pc_next", inst_pc_next, 16'h0002);
    check("c2_occ", occupancy, 1);
    check("c2_wrap_addr", wp_imem_addr, 16'h0000);
    check("c2_wrap_inst_pc", wp_inst_pc, 16'hFFFC);
    check("c2_wrap_inst", wp_inst, 16'h2FFC);
    check("c2_wrap_occ", wp_occupancy, 1);
    cyc(); #1;
    check("c3_inst_pc", inst_pc, 16'h0002);
    check("c3_addr", imem_addr, 16'h0006);
    check("c3_wrap_inst_pc", wp_inst_pc, 16'hFFFE);
    check("c3_wrap_pc_next", wp_inst_pc_next, 16'h0000);
    check("c3_wrap_valid", wp_inst_valid, 1);
    cyc(); #1;
    check("c4_req", imem_req, 0);
    check("c4_inst_pc", inst_pc, 16'h0004);
    cyc(); #1;
    check("c5_inst_pc", inst_pc, 16'h0006);
    check("c5_inst", inst, 16'hF000);
    check("c5_halted", halted, 0);
    cyc(); #1;
    check("c6_halted", halted, 1);
    check("c6_valid", inst_valid, 0);
    check("c6_req", imem_req, 0);
    cyc(); cyc();
    hlt_en = 1'b0;
    #1 check("c8_halted", halted, 1);

    // Redirect out of halt with decode stalled: queue saturates, then drains in order.
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0000; inst_ready = 1'b0;
    #1;
    check("b0_req", imem_req, 0);
    check("b0_halted", halted, 1);
    cyc();
    redirect = 1'b0;
    #1;
    check("b1_req", imem_req, 1);
    check("b1_addr", imem_addr, 16'h0000);
    check("b1_halted", halted, 0);
    cyc(); cyc(); #1;
    check("b3_valid", inst_valid, 1);
    check("b3_inst_pc", inst_pc, 16'h0000);
    repeat (6) cyc();
    #1;
    check("b9_occ", occupancy, 4);
    check("b9_req", imem_req, 0);
    cyc();
    inst_ready = 1'b1;
    #1;
    check("b10_req", imem_req, 0);
    check("b10_inst_pc", inst_pc, 16'h0000);
    cyc(); #1;
    check("b11_req", imem_req, 1);
    check("b11_addr", imem_addr, 16'h0008);
    check("b11_inst_pc", inst_pc, 16'h0002);
    cyc(); cyc(); cyc(); #1;
    check("b14_inst_pc", inst_pc, 16'h0008);
    check("b14_occ", occupancy, 2);

    // Redirect with three queued entries and one request in flight.
    cyc();
    inst_ready = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    check("k0_occ", occupancy, 3);
    check("k0_req", imem_req, 0);
    cyc();
    redirect = 1'b0; inst_ready = 1'b1;
    #1;
    check("k1_occ", occupancy, 0);
    check("k1_valid", inst_valid, 0);
    check("k1_req", imem_req, 1);
    check("k1_addr", imem_addr, 16'h0040);
    cyc(); cyc(); #1;
    check("k3_valid", inst_valid, 1);
    check("k3_inst_pc", inst_pc, 16'h0040);
    check("k3_pc_next", inst_pc_next, 16'h0042);

    // Address wrap through redirect.
    repeat (3) cyc();
    cyc();
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    cyc();
    redirect = 1'b0;
    cyc(); cyc(); #1;
    check("w3_inst_pc", inst_pc, 16'hFFFC);
    cyc(); #1;
    check("w4_inst_pc", inst_pc, 16'hFFFE);
    check("w4_pc_next", inst_pc_next, 16'h0000);
    cyc(); #1;
    check("w5_inst_pc", inst_pc, 16'h0000);

    // Asynchronous reset with a full queue.
    cyc();
    inst_ready = 1'b0;
    repeat (7) cyc();
    #1 check("e_full_occ", occupancy, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("e_rst_req", imem_req, 0);
    check("e_rst_valid", inst_valid, 0);
    check("e_rst_inst", inst, 0);
    check("e_rst_inst_pc", inst_pc, 0);
    check("e_rst_halted", halted, 0);
    check("e_rst_occ", occupancy, 0);
    check("e_rst_pc", pc, 16'h0000);
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("e0_req", imem_req, 1);
    check("e0_addr", imem_addr, 16'h0000);
    cyc(); cyc(); #1;
    check("e2_valid", inst_valid, 1);
    check("e2_inst_pc", inst_pc, 16'h0000);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
